// File: rtl/a3_id_ex_stage_if.sv
// Decode-to-execute bus: IF/ID request, register file read port, writeback forward
// path and the ID/EX pipeline register outputs.
interface a3_id_ex_stage_if;
  logic       if_valid;
  logic [7:0] instr;
  logic       id_ready;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       wb_WriteReg;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       ex_ready;
  logic       ex_valid;
  logic [1:0] ex_op;
  logic [2:0] ex_rd;
  logic [7:0] ex_a;
  logic [7:0] ex_b;
  logic       ex_WriteReg;
  logic [7:0] stall_count;

  modport master (
    output if_valid, instr, data1, data2, wb_WriteReg, wb_rd, wb_data, ex_ready,
    input  id_ready, rs1, rs2, ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_WriteReg, stall_count
  );

  modport slave (
    input  if_valid, instr, data1, data2, wb_WriteReg, wb_rd, wb_data, ex_ready,
    output id_ready, rs1, rs2, ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_WriteReg, stall_count
  );
endinterface

// File: rtl/a3_id_ex_stage.sv
// Decode stage: register read, writeback forwarding, RAW hazard detection and the
// ID/EX pipeline register under valid/ready flow control.
module a3_id_ex_stage (
  input logic              clk,
  input logic              reset,
  a3_id_ex_stage_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StFull, StStall} state_e;

  state_e     r_state, w_state_d;
  logic [1:0] r_ex_op;
  logic [2:0] r_ex_rd;
  logic [7:0] r_ex_a, r_ex_b, r_stall_count;
  logic       r_ex_wr;

  logic [1:0] w_op;
  logic [2:0] w_rs1, w_rs2;
  logic [7:0] w_a, w_b;
  logic       w_ex_valid, w_hazard, w_id_ready, w_transfer, w_writes;

  assign w_op     = bus.instr[7:6];
  assign w_rs1    = bus.instr[5:3];
  assign w_rs2    = bus.instr[2:0];
  assign w_writes = (w_op != 2'b11);

  assign w_a = (bus.wb_WriteReg && (bus.wb_rd == w_rs1)) ? bus.wb_data : bus.data1;
  assign w_b = (bus.wb_WriteReg && (bus.wb_rd == w_rs2)) ? bus.wb_data : bus.data2;

  assign w_ex_valid = (r_state != StEmpty);
  assign w_hazard   = bus.if_valid && w_writes && w_ex_valid && r_ex_wr &&
                      ((r_ex_rd == w_rs1) || (r_ex_rd == w_rs2));
  assign w_id_ready = !reset && !w_hazard && (!w_ex_valid || bus.ex_ready);
  assign w_transfer = bus.if_valid && w_id_ready;

  // A hazard with ex_ready high drains EX and lands in EMPTY, i.e. a bubble.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StEmpty: begin
        if (w_transfer) w_state_d = StFull;
      end
      StFull, StStall: begin
        if (w_transfer)        w_state_d = StFull;
        else if (bus.ex_ready) w_state_d = StEmpty;
        else if (w_hazard)     w_state_d = StStall;
        else                   w_state_d = StFull;
      end
      default: w_state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StEmpty;
      r_ex_op       <= 2'b11;
      r_ex_rd       <= 3'd0;
      r_ex_a        <= 8'd0;
      r_ex_b        <= 8'd0;
      r_ex_wr       <= 1'b0;
      r_stall_count <= 8'd0;
    end else begin
      r_state <= w_state_d;
      if (w_transfer) begin
        r_ex_op <= w_op;
        r_ex_rd <= w_rs1;
        r_ex_a  <= w_a;
        r_ex_b  <= w_b;
        r_ex_wr <= w_writes;
      end else if (w_ex_valid && bus.ex_ready) begin
        r_ex_wr <= 1'b0;
      end
      if (w_hazard && (r_stall_count != 8'hFF)) begin
        r_stall_count <= r_stall_count + 8'd1;
      end
    end
  end

  assign bus.id_ready    = w_id_ready;
  assign bus.rs1         = w_rs1;
  assign bus.rs2         = w_rs2;
  assign bus.ex_valid    = w_ex_valid;
  assign bus.ex_op       = r_ex_op;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.ex_a        = r_ex_a;
  assign bus.ex_b        = r_ex_b;
  assign bus.ex_WriteReg = r_ex_wr;
  assign bus.stall_count = r_stall_count;

endmodule

// File: doc/a3_id_ex_stage.md
A3_ID_EX_STAGE -- requirements
Module: a3_id_ex_stage

Purpose: instruction-decode stage that drives the 8x8 register file read ports, forwards writeback results, detects RAW hazards, and holds the ID/EX pipeline register under valid/ready flow control.

Parameters
REQ-001 The block SHALL have no parameters; data width is 8, register address width is 3.

Interface
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk          in   1  sole clock; all state updates on rising edge
- reset        in   1  synchronous, active-high reset
- if_valid     in   1  instr valid from IF/ID
- instr        in   8  [7:6] op, [5:3] rd/rs1, [2:0] rs2
- id_ready     out  1  stage accepts instr this cycle
- rs1          out  3  register file read address 1 = instr[5:3]
- rs2          out  3  register file read address 2 = instr[2:0]
- data1        in   8  register file read data 1
- data2        in   8  register file read data 2
- wb_WriteReg  in   1  writeback write enable
- wb_rd        in   3  writeback destination register
- wb_data      in   8  writeback data
- ex_ready     in   1  EX stage accepts ID/EX contents
- ex_valid     out  1  ID/EX register holds a valid instruction
- ex_op        out  2  registered opcode
- ex_rd        out  3  registered destination register
- ex_a         out  8  registered operand A
- ex_b         out  8  registered operand B
- ex_WriteReg  out  1  registered write enable
- stall_count  out  8  saturating count of hazard-stall cycles

Function
REQ-003 Opcodes SHALL be: 00 ADD, 01 SUB, 10 MOV, 11 NOP; only ops 00, 01 and 10 write rd.
REQ-004 rs1 and rs2 SHALL be combinational copies of instr[5:3] and instr[2:0], driven regardless of if_valid.
REQ-005 Operand A SHALL be wb_data when wb_WriteReg=1 and wb_rd==rs1; otherwise it SHALL be data1. Operand B SHALL be selected the same way using rs2 and data2.
REQ-006 A hazard SHALL exist when all of the following hold: if_valid=1, op!=11, ex_valid=1, ex_WriteReg=1, and ex_rd equals rs1 or rs2.
REQ-007 id_ready SHALL equal !reset && !hazard && (!ex_valid || ex_ready), combinationally.
REQ-008 A transfer SHALL occur when if_valid && id_ready. On a transfer, the next edge SHALL load ex_op, ex_rd, ex_a, ex_b and ex_WriteReg=(op!=11), and set ex_valid=1.
REQ-009 When ex_valid && ex_ready and no transfer occurs, the next edge SHALL clear ex_valid to 0; this is the bubble. The other ex_* outputs SHALL hold their values, except ex_WriteReg, which SHALL clear to 0.
REQ-010 When ex_valid && !ex_ready, all ex_* outputs SHALL hold, and id_ready SHALL be 0.
REQ-011 The FSM SHALL have three states.
- EMPTY: ex_valid=0.
- FULL: ex_valid=1, no hazard.
- STALL: ex_valid=1 and hazard.
REQ-012 FSM transitions SHALL be as follows.
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on ex_ready with no transfer.
- FULL -> FULL on a transfer.
- FULL <-> STALL as the hazard asserts or clears.
- STALL -> EMPTY on ex_ready, which issues the bubble.
REQ-013 stall_count SHALL increment by 1 on each cycle in which a hazard exists, and SHALL saturate at 255 with no wrap-around.
REQ-014 When a hazard and a wb forward occur in the same cycle, the hazard SHALL take precedence and no transfer SHALL occur.
REQ-015 A NOP SHALL transfer with ex_WriteReg=0, and SHALL never raise a hazard.

Reset
REQ-016 While reset=1 at a rising edge, the next state SHALL be as follows.
- ex_valid=0, ex_op=2'b11, ex_rd=0, ex_a=0, ex_b=0, ex_WriteReg=0.
- stall_count=0, FSM=EMPTY.
REQ-017 While reset=1, id_ready SHALL be 0 and no transfer SHALL occur.
REQ-018 Reset asserted mid-operation, including in STALL, SHALL discard the held instruction, with no partial update.

Verification
REQ-019 Basic transfer: reset, then instr=8'b00_001_010, data1=8'h05, data2=8'h03, ex_ready=1 -> next cycle ex_valid=1, ex_op=00, ex_rd=1, ex_a=05, ex_b=03, ex_WriteReg=1.
REQ-020 Forwarding: wb_WriteReg=1, wb_rd=2, wb_data=8'h7F, instr reads rs2=2 with data2=8'h00 -> ex_b=8'h7F.
REQ-021 Hazard: ex holds rd=3 with WriteReg=1, next instr reads rs1=3 -> id_ready=0 and stall_count increments. With ex_ready=1, the next cycle gives ex_valid=0 (bubble); the following cycle the instr transfers.
REQ-022 Back-pressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0 throughout, stall_count unchanged.
REQ-023 Saturation and reset: hold a hazard for 300 cycles -> stall_count=255. Then assert reset for 1 cycle -> stall_count=0, ex_valid=0, ex_op=11.
